// File: rtl/axi_tag_tracker_if.sv
// Request/completion/timeout bundle for the non-posted tag tracker.
// The master side drives allocation requests, completions and timeout acceptance;
// the slave side (the tracker) returns grants, lookup results and timeout records.
interface axi_tag_tracker_if #(
  parameter int NUM_TAGS     = 32,
  parameter int TAG_WIDTH    = $clog2(NUM_TAGS),
  parameter int AXI_ID_WIDTH = 4,
  parameter int LEN_WIDTH    = 10
);
  logic                    alloc_req;
  logic [AXI_ID_WIDTH-1:0] alloc_axi_id;
  logic [LEN_WIDTH-1:0]    alloc_len;
  logic                    alloc_grant;
  logic [TAG_WIDTH-1:0]    alloc_tag;
  logic                    tags_available;
  logic [TAG_WIDTH:0]      outstanding_cnt;

  logic                    cpl_valid;
  logic [TAG_WIDTH-1:0]    cpl_tag;
  logic [LEN_WIDTH-1:0]    cpl_len;
  logic [2:0]              cpl_status;

  logic                    rsp_valid;
  logic [AXI_ID_WIDTH-1:0] rsp_axi_id;
  logic                    rsp_last;
  logic                    rsp_unexpected;
  logic                    rsp_error;

  logic                    to_valid;
  logic [TAG_WIDTH-1:0]    to_tag;
  logic [AXI_ID_WIDTH-1:0] to_axi_id;
  logic                    to_ready;

  modport master (
    output alloc_req, alloc_axi_id, alloc_len,
    input  alloc_grant, alloc_tag, tags_available, outstanding_cnt,
    output cpl_valid, cpl_tag, cpl_len, cpl_status,
    input  rsp_valid, rsp_axi_id, rsp_last, rsp_unexpected, rsp_error,
    input  to_valid, to_tag, to_axi_id,
    output to_ready
  );

  modport slave (
    input  alloc_req, alloc_axi_id, alloc_len,
    output alloc_grant, alloc_tag, tags_available, outstanding_cnt,
    input  cpl_valid, cpl_tag, cpl_len, cpl_status,
    output rsp_valid, rsp_axi_id, rsp_last, rsp_unexpected, rsp_error,
    output to_valid, to_tag, to_axi_id,
    input  to_ready
  );
endinterface

// File: rtl/axi_tag_tracker.sv
// Non-posted request tag tracker: allocates tags to AXI reads, matches returning
// completions against the remaining DW count, and runs a per-tag completion
// timeout whose expired tags are handed off through a valid/ready record.
module axi_tag_tracker #(
  parameter int NUM_TAGS       = 32,
  parameter int TAG_WIDTH      = $clog2(NUM_TAGS),
  parameter int AXI_ID_WIDTH   = 4,
  parameter int LEN_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMER_WIDTH    = 16
) (
  input logic              axi_clk,
  input logic              ARESET,
  axi_tag_tracker_if.slave bus
);
  typedef enum logic [1:0] {
    TAG_FREE    = 2'd0,
    TAG_PENDING = 2'd1,
    TAG_EXPIRED = 2'd2
  } tag_state_e;

  localparam int                     REM_W       = LEN_WIDTH + 1;
  localparam logic [REM_W-1:0]       FULL_LEN    = {1'b1, {LEN_WIDTH{1'b0}}};
  localparam bit                     TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(TIMEOUT_CYCLES);

  // A zero length field stands for the maximum transfer size.
  function automatic logic [REM_W-1:0] decode_len(input logic [LEN_WIDTH-1:0] len);
    decode_len = (len == '0) ? FULL_LEN : {1'b0, len};
  endfunction

  tag_state_e              state_q     [NUM_TAGS];
  tag_state_e              state_d     [NUM_TAGS];
  logic [AXI_ID_WIDTH-1:0] axi_id_q    [NUM_TAGS];
  logic [AXI_ID_WIDTH-1:0] axi_id_d    [NUM_TAGS];
  logic [REM_W-1:0]        remaining_q [NUM_TAGS];
  logic [REM_W-1:0]        remaining_d [NUM_TAGS];
  logic [TIMER_WIDTH-1:0]  timer_q     [NUM_TAGS];
  logic [TIMER_WIDTH-1:0]  timer_d     [NUM_TAGS];

  logic                    free_found;
  logic [TAG_WIDTH-1:0]    free_idx;
  logic [TAG_WIDTH:0]      busy_cnt;
  logic                    alloc_grant;

  logic [REM_W-1:0]        cpl_dw;
  logic                    cpl_hit;
  logic                    cpl_sc;
  logic                    cpl_close;

  logic                    rsp_valid_q, rsp_valid_d;
  logic [AXI_ID_WIDTH-1:0] rsp_axi_id_q, rsp_axi_id_d;
  logic                    rsp_last_q, rsp_last_d;
  logic                    rsp_unexpected_q, rsp_unexpected_d;
  logic                    rsp_error_q, rsp_error_d;

  logic                    exp_found;
  logic [TAG_WIDTH-1:0]    exp_idx;
  logic                    to_accept;
  logic                    to_valid_q, to_valid_d;
  logic [TAG_WIDTH-1:0]    to_tag_q, to_tag_d;
  logic [AXI_ID_WIDTH-1:0] to_axi_id_q, to_axi_id_d;

  // Lowest free tag and the count of tags in use, both from registered state so a
  // tag freed this cycle only becomes grantable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    busy_cnt   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (state_q[i] == TAG_FREE) begin
        free_found = 1'b1;
        free_idx   = TAG_WIDTH'(i);
      end else begin
        busy_cnt = busy_cnt + 1'b1;
      end
    end
  end

  assign alloc_grant = bus.alloc_req & free_found & ~ARESET;

  // Completion lookup against the addressed tag.
  always_comb begin
    cpl_dw    = decode_len(bus.cpl_len);
    cpl_sc    = (bus.cpl_status == 3'b000);
    cpl_hit   = bus.cpl_valid & (state_q[bus.cpl_tag] == TAG_PENDING);
    cpl_close = cpl_hit & (~cpl_sc | (cpl_dw >= remaining_q[bus.cpl_tag]));

    rsp_valid_d      = bus.cpl_valid;
    rsp_axi_id_d     = bus.cpl_valid ? axi_id_q[bus.cpl_tag] : '0;
    rsp_last_d       = cpl_close;
    rsp_unexpected_d = bus.cpl_valid & ~cpl_hit;
    rsp_error_d      = bus.cpl_valid & ~cpl_sc;
  end

  assign to_accept = to_valid_q & bus.to_ready;

  // Per-tag table update; completion, timeout accept and allocation never touch
  // the same tag because each acts on a different tag state.
  always_comb begin
    state_d     = state_q;
    axi_id_d    = axi_id_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (state_q[i] == TAG_PENDING) begin
        // Timer saturates at the limit so a tag kept alive by a partial
        // completion on the expiry cycle still expires on the following one.
        if (!TIMEOUT_EN || timer_q[i] != TIMEOUT_VAL) begin
          timer_d[i] = timer_q[i] + 1'b1;
        end
        if (cpl_hit && bus.cpl_tag == TAG_WIDTH'(i)) begin
          if (cpl_close) begin
            state_d[i] = TAG_FREE;
          end else begin
            remaining_d[i] = remaining_q[i] - cpl_dw;
          end
        end else if (TIMEOUT_EN && timer_d[i] == TIMEOUT_VAL) begin
          state_d[i] = TAG_EXPIRED;
        end
      end
      if (to_accept && to_tag_q == TAG_WIDTH'(i)) begin
        state_d[i] = TAG_FREE;
      end
      if (alloc_grant && free_idx == TAG_WIDTH'(i)) begin
        state_d[i]     = TAG_PENDING;
        axi_id_d[i]    = bus.alloc_axi_id;
        remaining_d[i] = decode_len(bus.alloc_len);
        timer_d[i]     = '0;
      end
    end
  end

  // Timeout record: latch the lowest expired tag and hold it until accepted.
  always_comb begin
    exp_found = 1'b0;
    exp_idx   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (state_d[i] == TAG_EXPIRED) begin
        exp_found = 1'b1;
        exp_idx   = TAG_WIDTH'(i);
      end
    end
    to_valid_d  = to_valid_q;
    to_tag_d    = to_tag_q;
    to_axi_id_d = to_axi_id_q;
    if (!to_valid_q || bus.to_ready) begin
      to_valid_d  = exp_found;
      to_tag_d    = exp_idx;
      to_axi_id_d = exp_found ? axi_id_q[exp_idx] : '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge axi_clk) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_q[i] <= TAG_FREE;
        timer_q[i] <= '0;
      end
      rsp_valid_q      <= 1'b0;
      rsp_axi_id_q     <= '0;
      rsp_last_q       <= 1'b0;
      rsp_unexpected_q <= 1'b0;
      rsp_error_q      <= 1'b0;
      to_valid_q       <= 1'b0;
      to_tag_q         <= '0;
      to_axi_id_q      <= '0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_axi_id_q     <= rsp_axi_id_d;
      rsp_last_q       <= rsp_last_d;
      rsp_unexpected_q <= rsp_unexpected_d;
      rsp_error_q      <= rsp_error_d;
      to_valid_q       <= to_valid_d;
      to_tag_q         <= to_tag_d;
      to_axi_id_q      <= to_axi_id_d;
    end
  end

  // Recorded ID and remaining count are only meaningful while a tag is in use.
  always_ff @(posedge axi_clk) begin
    axi_id_q    <= axi_id_d;
    remaining_q <= remaining_d;
  end

  assign bus.alloc_grant     = alloc_grant;
  assign bus.alloc_tag       = free_idx;
  assign bus.tags_available  = free_found;
  assign bus.outstanding_cnt = busy_cnt;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_axi_id      = rsp_axi_id_q;
  assign bus.rsp_last        = rsp_last_q;
  assign bus.rsp_unexpected  = rsp_unexpected_q;
  assign bus.rsp_error       = rsp_error_q;
  assign bus.to_valid        = to_valid_q;
  assign bus.to_tag          = to_tag_q;
  assign bus.to_axi_id       = to_axi_id_q;
endmodule

// File: tb/tb_axi_tag_tracker.sv
// Bench for axi_tag_tracker: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural tag-table model.
module tb_axi_tag_tracker;
  localparam int NT = 32;
  localparam int TW = 5;
  localparam int IW = 4;
  localparam int LW = 10;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_tag_tracker_if #(.NUM_TAGS(NT), .TAG_WIDTH(TW), .AXI_ID_WIDTH(IW), .LEN_WIDTH(LW)) ifc ();

  axi_tag_tracker #(
    .NUM_TAGS(NT), .TAG_WIDTH(TW), .AXI_ID_WIDTH(IW), .LEN_WIDTH(LW),
    .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(16)
  ) dut (
    .axi_clk(clk),
    .ARESET (rst),
    .bus    (ifc)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the current cycle.
  bit       d_rst, d_req, d_cv, d_tr;
  bit [3:0] d_id;
  bit [9:0] d_alen, d_cl;
  bit [4:0] d_ct;
  bit [2:0] d_cs;

  // Behavioural model: 0 = free, 1 = waiting for data, 2 = timed out.
  int m_st  [NT];
  int m_id  [NT];
  int m_rem [NT];
  int m_age [NT];
  bit m_ever[NT];
  bit m_known = 1'b0;
  bit m_tov;
  int m_tot;
  bit e_rv, e_last, e_unx, e_err, e_idchk;
  int e_id;

  bit last_grant;
  int last_tag;

  task automatic idle();
    d_rst = 0; d_req = 0; d_id = 0; d_alen = 0;
    d_cv = 0; d_ct = 0; d_cl = 0; d_cs = 0; d_tr = 0;
  endtask

  task automatic model_update(input bit g, input int gtag);
    bit tov_old;
    if (d_rst) begin
      for (int i = 0; i < NT; i++) begin
        m_st[i] = 0; m_age[i] = 0;
      end
      m_tov = 0; m_tot = 0;
      e_rv = 0; e_last = 0; e_unx = 0; e_err = 0; e_idchk = 0; e_id = 0;
      m_known = 1;
      return;
    end
    tov_old = m_tov;
    e_rv = d_cv; e_last = 0; e_unx = 0; e_err = 0;
    e_id = m_id[d_ct]; e_idchk = d_cv && m_ever[d_ct];
    // Ageing: an untouched waiting tag times out once it has waited TO cycles.
    for (int i = 0; i < NT; i++) begin
      if (m_st[i] == 1) begin
        m_age[i]++;
        if (m_age[i] >= TO && !(d_cv && d_ct == i)) m_st[i] = 2;
      end
    end
    if (d_cv) begin
      e_err = (d_cs != 0);
      if (m_st[d_ct] == 1) begin
        if (d_cs != 0) e_last = 1;
        else begin
          m_rem[d_ct] -= (d_cl == 0) ? 1024 : int'(d_cl);
          if (m_rem[d_ct] <= 0) e_last = 1;
        end
        if (e_last) m_st[d_ct] = 0;
      end else begin
        e_unx = 1;
      end
    end
    if (tov_old && d_tr) m_st[m_tot] = 0;
    if (g) begin
      m_st[gtag] = 1; m_id[gtag] = d_id; m_age[gtag] = 0; m_ever[gtag] = 1;
      m_rem[gtag] = (d_alen == 0) ? 1024 : int'(d_alen);
    end
    if (!tov_old || d_tr) begin
      m_tov = 0;
      for (int i = NT - 1; i >= 0; i--) begin
        if (m_st[i] == 2) begin m_tov = 1; m_tot = i; end
      end
    end
  endtask

  // One clock: apply inputs, check every visible output against the model, advance.
  task automatic tick();
    bit exp_av, exp_g;
    int lf, cnt;
    rst = d_rst;
    ifc.alloc_req = d_req; ifc.alloc_axi_id = d_id; ifc.alloc_len = d_alen;
    ifc.cpl_valid = d_cv; ifc.cpl_tag = d_ct; ifc.cpl_len = d_cl; ifc.cpl_status = d_cs;
    ifc.to_ready = d_tr;
    #1;
    exp_av = 0; lf = 0; cnt = 0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (m_st[i] == 0) begin exp_av = 1; lf = i; end
      else cnt++;
    end
    exp_g = d_req && exp_av && !d_rst;
    last_grant = ifc.alloc_grant;
    last_tag   = int'(ifc.alloc_tag);
    if (m_known || d_rst) check_val("alloc_grant", 32'(ifc.alloc_grant), 32'(exp_g));
    if (m_known) begin
      check_val("tags_available", 32'(ifc.tags_available), 32'(exp_av));
      check_val("outstanding_cnt", 32'(ifc.outstanding_cnt), 32'(cnt));
      if (exp_av) check_val("alloc_tag", 32'(ifc.alloc_tag), 32'(lf));
      check_val("to_valid", 32'(ifc.to_valid), 32'(m_tov));
      if (m_tov) begin
        check_val("to_tag", 32'(ifc.to_tag), 32'(m_tot));
        check_val("to_axi_id", 32'(ifc.to_axi_id), 32'(m_id[m_tot]));
      end
      check_val("rsp_valid", 32'(ifc.rsp_valid), 32'(e_rv));
      if (e_rv) begin
        check_val("rsp_last", 32'(ifc.rsp_last), 32'(e_last));
        check_val("rsp_unexpected", 32'(ifc.rsp_unexpected), 32'(e_unx));
        check_val("rsp_error", 32'(ifc.rsp_error), 32'(e_err));
        if (e_idchk) check_val("rsp_axi_id", 32'(ifc.rsp_axi_id), 32'(e_id));
      end
    end
    @(posedge clk);
    model_update(exp_g, lf);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); d_rst = 1; tick(); tick(); idle();
    check_val("rst_avail", 32'(ifc.tags_available), 32'd1);
    check_val("rst_cnt", 32'(ifc.outstanding_cnt), 32'd0);
    check_val("rst_to_valid", 32'(ifc.to_valid), 32'd0);
    check_val("rst_to_tag", 32'(ifc.to_tag), 32'd0);
    check_val("rst_to_axi_id", 32'(ifc.to_axi_id), 32'd0);
    check_val("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check_val("rst_rsp_flags", {29'd0, ifc.rsp_last, ifc.rsp_unexpected, ifc.rsp_error}, 32'd0);
    check_val("rst_rsp_axi_id", 32'(ifc.rsp_axi_id), 32'd0);
  endtask

  task automatic alloc(input bit [3:0] id, input bit [9:0] len);
    idle(); d_req = 1; d_id = id; d_alen = len; tick(); idle();
  endtask

  task automatic cpl(input bit [4:0] t, input bit [9:0] len, input bit [2:0] st);
    idle(); d_cv = 1; d_ct = t; d_cl = len; d_cs = st; tick(); idle();
  endtask

  initial begin
    int lat;
    idle();
    rst = 1;
    ifc.alloc_req = 0; ifc.alloc_axi_id = 0; ifc.alloc_len = 0;
    ifc.cpl_valid = 0; ifc.cpl_tag = 0; ifc.cpl_len = 0; ifc.cpl_status = 0;
    ifc.to_ready = 0;
    for (int i = 0; i < NT; i++) begin
      m_st[i] = 0; m_id[i] = 0; m_rem[i] = 0; m_age[i] = 0; m_ever[i] = 0;
    end
    @(negedge clk);
    do_reset();

    // Fill all tags in order, then a refused request.
    for (int i = 0; i < NT; i++) begin
      alloc(4'(i % 16), 10'($urandom_range(1, 200)));
      check_val("fill_tag", 32'(last_tag), 32'(i));
    end
    check_val("full_avail", 32'(ifc.tags_available), 32'd0);
    check_val("full_cnt", 32'(ifc.outstanding_cnt), 32'd32);
    alloc(4'd0, 10'd1);
    check_val("full_grant", 32'(last_grant), 32'd0);
    for (int i = 0; i < NT; i++) cpl(5'(i), 10'd0, 3'd0);
    check_val("drain_cnt", 32'(ifc.outstanding_cnt), 32'd0);

    // Split completion 8 + 8 on a 16 DW read, then reuse of the tag.
    alloc(4'd9, 10'd16);
    cpl(5'd0, 10'd8, 3'd0);
    check_val("split_last0", 32'(ifc.rsp_last), 32'd0);
    cpl(5'd0, 10'd8, 3'd0);
    check_val("split_last1", 32'(ifc.rsp_last), 32'd1);
    alloc(4'd2, 10'd4);
    check_val("reuse_tag0", 32'(last_tag), 32'd0);

    // Completion to a free tag.
    cpl(5'd5, 10'd1, 3'd0);
    check_val("unexp_free", 32'(ifc.rsp_unexpected), 32'd1);
    check_val("unexp_cnt", 32'(ifc.outstanding_cnt), 32'd1);

    // Timeout of tag 3 with the record held, late completion, then accept.
    do_reset();
    alloc(4'd1, 10'd1); alloc(4'd1, 10'd1); alloc(4'd1, 10'd1);
    alloc(4'd7, 10'd32);
    check_val("to_alloc_tag", 32'(last_tag), 32'd3);
    lat = -1;
    for (int n = 1; n <= 150 && lat < 0; n++) begin
      if (n <= 3) cpl(5'(n - 1), 10'd1, 3'd0);
      else begin idle(); tick(); end
      if (ifc.to_valid) lat = n;
    end
    check_val("to_latency", 32'(lat), 32'd100);
    for (int n = 0; n < 5; n++) begin idle(); tick(); end
    check_val("to_hold_tag", 32'(ifc.to_tag), 32'd3);
    check_val("to_hold_id", 32'(ifc.to_axi_id), 32'd7);
    cpl(5'd3, 10'd32, 3'd0);
    check_val("to_late_unexp", 32'(ifc.rsp_unexpected), 32'd1);
    check_val("to_still_valid", 32'(ifc.to_valid), 32'd1);
    idle(); d_tr = 1; tick(); idle();
    check_val("to_freed_cnt", 32'(ifc.outstanding_cnt), 32'd0);

    // Non-SC completion on tag 1 with 64 DW outstanding.
    alloc(4'd3, 10'd4); alloc(4'd5, 10'd64);
    cpl(5'd1, 10'd16, 3'b100);
    check_val("err_flag", 32'(ifc.rsp_error), 32'd1);
    check_val("err_last", 32'(ifc.rsp_last), 32'd1);
    check_val("err_cnt", 32'(ifc.outstanding_cnt), 32'd1);

    // Tag freed and requested in the same cycle.
    do_reset();
    for (int i = 0; i < NT; i++) alloc(4'(i), 10'd8);
    idle(); d_cv = 1; d_ct = 5'd2; d_cl = 10'd8; d_req = 1; d_id = 4'd11; d_alen = 10'd3;
    tick();
    check_val("same_cycle_grant", 32'(last_grant), 32'd0);
    alloc(4'd11, 10'd3);
    check_val("next_cycle_grant", 32'(last_grant), 32'd1);
    check_val("next_cycle_tag", 32'(last_tag), 32'd2);

    // Random traffic including mid-operation resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      d_rst  = ($urandom % 700) == 0;
      d_req  = ($urandom % 2) == 0;
      d_id   = 4'($urandom);
      d_alen = (($urandom % 16) == 0) ? 10'd0 : 10'($urandom_range(1, 64));
      d_cv   = ($urandom % 3) != 0;
      d_ct   = 5'($urandom);
      d_cl   = (($urandom % 10) == 0) ? 10'd0 : 10'($urandom_range(1, 24));
      d_cs   = (($urandom % 12) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      d_tr   = ($urandom % 3) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_tag_tracker.md
# axi_tag_tracker

Parametrised non-posted request tag tracker for the AXI slave request/response path. It allocates PCIe tags to outgoing AXI read requests and records the AXI ID and expected DW count for each tag. It matches returning completions to their tags, counts down the remaining length, and flags unexpected completions. It runs a per-tag completion-timeout timer and hands expired tags to the internal error-response generator. It replaces the single-entry request recording with NUM_TAGS concurrent outstanding requests and adds timeout behaviour.

## Interface
- NUM_TAGS, 32: concurrent outstanding tags (power of 2, 2..256).
- TAG_WIDTH, $clog2(NUM_TAGS): tag field width.
- AXI_ID_WIDTH, 4: recorded AXI ID width.
- LEN_WIDTH, 10: DW length field width; a value of 0 encodes 1024 DW.
- TIMEOUT_CYCLES, 65535: cycles from allocation to timeout; 0 disables timeouts.
- TIMER_WIDTH, 16: per-tag timer width; must satisfy TIMEOUT_CYCLES < 2^TIMER_WIDTH.
- axi_clk  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- alloc_req  in  1  request a tag for a non-posted read.
- alloc_axi_id  in  AXI_ID_WIDTH  AXI ID to record.
- alloc_len  in  LEN_WIDTH  total DWs expected.
- alloc_grant  out  1  allocation accepted this cycle.
- alloc_tag  out  TAG_WIDTH  granted tag.
- tags_available  out  1  at least one tag is FREE.
- outstanding_cnt  out  TAG_WIDTH+1  number of tags not FREE.
- cpl_valid  in  1  completion header strobe.
- cpl_tag  in  TAG_WIDTH  completion tag.
- cpl_len  in  LEN_WIDTH  DWs carried by this completion.
- cpl_status  in  3  completion status; 3'b000 means SC.
- rsp_valid  out  1  registered lookup result.
- rsp_axi_id  out  AXI_ID_WIDTH  AXI ID of the matched tag.
- rsp_last  out  1  this completion closes the tag.
- rsp_unexpected  out  1  tag was not PENDING.
- rsp_error  out  1  status was not SC.
- to_valid  out  1  timeout record pending.
- to_tag  out  TAG_WIDTH  expired tag.
- to_axi_id  out  AXI_ID_WIDTH  AXI ID of the expired tag.
- to_ready  in  1  error generator accepts the timeout record.

## Operation
- Each tag has a 2-bit state (FREE, PENDING, EXPIRED), a recorded axi_id, a remaining-DW count of LEN_WIDTH+1 bits, and a timer.
- Allocation:
  - alloc_grant = alloc_req & tags_available, evaluated combinationally.
  - alloc_tag is the lowest-indexed FREE tag.
  - On grant, the tag goes FREE→PENDING, axi_id is stored, remaining = (alloc_len==0 ? 1024 : alloc_len), and the timer is cleared.
- Completion, when cpl_valid is high, based on the state of cpl_tag:
  - PENDING, SC: remaining -= cpl_len (0 encodes 1024). If the result is ≤ 0, rsp_last=1 and the tag goes to FREE.
  - PENDING, non-SC: rsp_error=1, rsp_last=1, tag goes to FREE.
  - FREE or EXPIRED: rsp_unexpected=1, rsp_last=0, and the tag state is unchanged.
  - rsp_axi_id always carries the stored ID of cpl_tag.
- Timer:
  - Increments each cycle while the tag is PENDING.
  - When the timer equals TIMEOUT_CYCLES, the tag goes PENDING→EXPIRED and the timer holds.
  - Tags do not time out when TIMEOUT_CYCLES is 0.
- Timeout handoff:
  - to_valid=1 when any tag is EXPIRED; to_tag is the lowest-indexed EXPIRED tag.
  - Valid/ready handshake: once asserted, to_valid, to_tag and to_axi_id remain stable until to_ready.
  - On to_valid & to_ready, the tag goes EXPIRED→FREE.
- Reset: all tags FREE, all timers 0.

## Timing
- Reset values of outputs: alloc_grant=0 (alloc_req ignored during ARESET), tags_available=1, outstanding_cnt=0, rsp_*=0, to_valid=0, to_tag=0, to_axi_id=0.
- Allocation: grant is combinational in the same cycle. Table state updates on the next edge; a second request in the next cycle sees the tag as taken.
- Completion: rsp_* is registered with 1-cycle latency after cpl_valid; rsp_valid is a single-cycle pulse.
- A tag freed in cycle N (by completion or timeout accept) is allocatable from cycle N+1. It is never re-granted in cycle N.
- Completion and expiry on the same tag in the same cycle: the completion wins and no EXPIRED transition occurs.
- Completion to a tag that is already EXPIRED (to_valid may be showing it) is unexpected. The timeout record is not withdrawn.
- Simultaneous allocation, completion and timeout accept on different tags are all applied in the same cycle. outstanding_cnt reflects the net change on the next edge.
- outstanding_cnt saturates at NUM_TAGS; alloc_grant=0 whenever tags_available=0.
- ARESET asserted mid-operation clears all state on the next edge. A pending to_valid drops without a handshake.

## Test plan
- Reset, then 32 back-to-back allocations with IDs 0..15 repeating → tags 0..31 granted in order; in the cycle after the 32nd grant, tags_available=0 and outstanding_cnt=32, and a 33rd alloc_req gets alloc_grant=0.
- Allocate tag 0 with len 16, then completions with len 8 and len 8 → first rsp_last=0, second rsp_last=1; tag 0 is re-granted on the next allocation.
- Completion with cpl_tag=5 while tag 5 is FREE → rsp_unexpected=1 one cycle later; outstanding_cnt unchanged.
- TIMEOUT_CYCLES=100: allocate tag 3 with ID 7 and hold to_ready=0 → to_valid rises after 100 cycles with to_tag=3 and to_axi_id=7, and holds stable. Then send a completion on tag 3 → rsp_unexpected=1. Pulse to_ready → tag 3 FREE the next cycle.
- Same-cycle completion closing tag 2 and alloc_req with only tag 2 free → alloc_grant=0 that cycle, grant of tag 2 the next cycle.
- Completion with non-SC status on tag 1 (len 64 outstanding) → rsp_error=1, rsp_last=1, tag 1 freed.
